lv2_bus_responder: RTL and testbench
====================================

Name: lv2_bus_responder

Overview:
- L2-side responder on the shared lv1–lv2 bus: services `lv2_rd` / `lv2_wr` requests issued by the L1 data/instruction cache blocks.
- Captures the request address (and write data), runs one transaction on the L2 array port, then completes the bus handshake:
  - read: drives data and `data_in_bus_lv1_lv2`;
  - write: drives `lv2_wr_done`.
- Sits between the lv1–lv2 bus and the L2 cache block.

Parameters:
- DATA_WID, 32, data bus width.
- ADDR_WID, 32, address bus width.
- MIN_LAT, 2, minimum cycles from request capture to completion (models L2 access time); range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- lv2_rd  in  1  L1 read request; level, held until data accepted.
- lv2_wr  in  1  L1 write request; level, held until done seen.
- addr_bus_lv1_lv2  in  ADDR_WID  request address.
- data_bus_lv1_lv2  inout  DATA_WID  write data in; read data out (tri-stated otherwise).
- data_in_bus_lv1_lv2  inout  1  driven 1 when read data valid, else Z.
- lv2_wr_done  out  1  write completion.
- mem_req  out  1  L2 array request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_WID  L2 array address.
- mem_wdata  out  DATA_WID  L2 array write data.
- mem_rdata  in  DATA_WID  L2 array read data.
- mem_ack  in  1  L2 array completion, 1-cycle pulse.
- busy  out  1  transaction in progress (state != IDLE).

Behaviour:
- Reset values: state IDLE; `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `lv2_wr_done`=0, `busy`=0.
  - data bus and `data_in_bus_lv1_lv2` tri-stated (Z); latency counter 0; read data register 0.
- States: IDLE, RD_ACC, RD_DRV, WR_ACC, WR_DONE.
- IDLE:
  - `lv2_rd`=1 → capture addr into `mem_addr`; `mem_req`=1, `mem_we`=0; counter=0; go RD_ACC.
  - `lv2_wr`=1 → capture addr and data bus into `mem_addr`/`mem_wdata`; `mem_req`=1, `mem_we`=1; go WR_ACC.
  - Both asserted in the same cycle → read wins; write stays pending and is taken on return to IDLE.
- RD_ACC / WR_ACC:
  - `mem_req` held until `mem_ack` is sampled; then `mem_req`=0 and rdata latched (read).
  - Counter increments every cycle, saturating at 15.
  - Exit when ack has been seen AND counter ≥ MIN_LAT−1, so completion occurs no earlier than MIN_LAT cycles after capture.
  - RD_ACC → RD_DRV; WR_ACC → WR_DONE.
- RD_DRV:
  - Data bus driven with latched rdata; `data_in_bus_lv1_lv2`=1.
  - Held until `lv2_rd`=0; bus released to Z in the same cycle that `lv2_rd` is sampled 0; return to IDLE.
- WR_DONE:
  - `lv2_wr_done`=1, held until `lv2_wr`=0; then 0 and return to IDLE.
- Request withdrawal:
  - Request deasserted during RD_ACC/WR_ACC → L2 transaction still completes (mem_ack awaited); then return to IDLE without driving the bus or asserting done.
- Back-to-back requests: at least one IDLE cycle between transactions; a request held across IDLE is re-sampled only after the previous handshake has closed.
- `mem_ack` outside the ACC states is ignored.
- Reset mid-transaction: immediate return to IDLE; all drivers released to Z; in-flight L2 transaction abandoned (the L2 side must also be reset).
- Address/data captured once per transaction; bus changes after capture have no effect.

Optional Feature:
- Macro LV2_RESP_STATS_EN.
- Defined: adds outputs `rd_count` and `wr_count` (32-bit each).
  - Each increments by 1 at entry to RD_DRV / WR_DONE respectively; withdrawn requests are not counted.
  - Wrap modulo 2^32; cleared by `rst`.
- Not defined: no counters and no such ports; behaviour otherwise identical.

Test Plan:
- Read, MIN_LAT=2: `lv2_rd`=1 with addr 0x0000_0040; `mem_ack` returned 1 cycle later with rdata 0xDEAD_BEEF → data bus = 0xDEAD_BEEF and `data_in_bus_lv1_lv2`=1 from 2 cycles after capture; both Z one cycle after `lv2_rd` drops.
- Write: `lv2_wr`=1, addr 0x0000_0080, data 0x1234_5678 → `mem_we`=1, `mem_addr`=0x80, `mem_wdata`=0x1234_5678; after `mem_ack`, `lv2_wr_done`=1 held until `lv2_wr`=0.
- Slow L2: `mem_ack` delayed 7 cycles → `mem_req` held 7 cycles; completion on the cycle after ack; bus not driven earlier.
- Simultaneous `lv2_rd` (addr 0x100) and `lv2_wr` (addr 0x200) → read serviced first; after `lv2_rd` drops and one IDLE cycle, write captured at 0x200.
- Reset asserted during RD_ACC → `mem_req`=0, bus Z, `busy`=0 in the same cycle as `rst`; new read after reset completes normally.
- With LV2_RESP_STATS_EN defined: 3 reads, 2 writes, 1 withdrawn read → `rd_count`=3, `wr_count`=2.

Source files
------------

// File: rtl/lv2_bus_responder_if.sv
// L2 array port between the lv1-lv2 bus responder (master) and the L2 cache block (slave).
interface lv2_bus_responder_if #(
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32
);
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_WID-1:0] mem_addr;
  logic [DATA_WID-1:0] mem_wdata;
  logic [DATA_WID-1:0] mem_rdata;
  logic                mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lv2_bus_responder.sv
// L2-side responder for the shared lv1-lv2 bus: one L2 array transaction per lv2_rd/lv2_wr request.
// Optional per-direction completion counters are enabled by defining LV2_RESP_STATS_EN.
module lv2_bus_responder #(
  parameter int DATA_WID = 32,
  parameter int ADDR_WID = 32,
  parameter int MIN_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lv2_rd,
  input  logic                lv2_wr,
  input  logic [ADDR_WID-1:0] addr_bus_lv1_lv2,
  inout  wire  [DATA_WID-1:0] data_bus_lv1_lv2,
  inout  wire                 data_in_bus_lv1_lv2,
  output logic                lv2_wr_done,
  lv2_bus_responder_if.master mem,
`ifdef LV2_RESP_STATS_EN
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count,
`endif
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, RD_ACC, RD_DRV, WR_ACC, WR_DONE} state_t;

  localparam logic [3:0] LAT_THRESH = 4'(MIN_LAT - 1);

  state_t              state;
  logic [3:0]          lat_cnt;
  logic                ack_seen;
  logic                withdrawn;
  logic                drive_q;
  logic [DATA_WID-1:0] rdata_q;

  logic lat_met;
  logic ack_now;
  logic req_live;

  assign lat_met  = (lat_cnt >= LAT_THRESH);
  assign ack_now  = ack_seen | mem.mem_ack;
  assign req_live = (state == RD_ACC) ? lv2_rd : lv2_wr;

  // Bus drivers come straight from registers so the bus never glitches.
  assign data_bus_lv1_lv2    = drive_q ? rdata_q : {DATA_WID{1'bz}};
  assign data_in_bus_lv1_lv2 = drive_q ? 1'b1 : 1'bz;
  assign busy                = (state != IDLE);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      ack_seen      <= 1'b0;
      withdrawn     <= 1'b0;
      drive_q       <= 1'b0;
      rdata_q       <= '0;
      lv2_wr_done   <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
`ifdef LV2_RESP_STATS_EN
      rd_count      <= '0;
      wr_count      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Read has priority; a simultaneous write stays pending on the bus.
          if (lv2_rd || lv2_wr) begin
            mem.mem_addr <= addr_bus_lv1_lv2;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= !lv2_rd;
            lat_cnt      <= '0;
            ack_seen     <= 1'b0;
            withdrawn    <= 1'b0;
            if (!lv2_rd) mem.mem_wdata <= data_bus_lv1_lv2;
            state <= lv2_rd ? RD_ACC : WR_ACC;
          end
        end

        RD_ACC, WR_ACC: begin
          if (lat_cnt != 4'd15) lat_cnt <= lat_cnt + 4'd1;
          if (mem.mem_ack && !ack_seen) begin
            ack_seen    <= 1'b1;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            if (state == RD_ACC) rdata_q <= mem.mem_rdata;
          end
          if (!req_live) withdrawn <= 1'b1;
          // A withdrawn request still waits out the L2 access, then closes silently.
          if (ack_now && lat_met) begin
            if (req_live && !withdrawn) begin
              if (state == RD_ACC) begin
                drive_q  <= 1'b1;
                state    <= RD_DRV;
`ifdef LV2_RESP_STATS_EN
                rd_count <= rd_count + 32'd1;
`endif
              end else begin
                lv2_wr_done <= 1'b1;
                state       <= WR_DONE;
`ifdef LV2_RESP_STATS_EN
                wr_count    <= wr_count + 32'd1;
`endif
              end
            end else begin
              state <= IDLE;
            end
          end
        end

        RD_DRV: begin
          if (!lv2_rd) begin
            drive_q <= 1'b0;
            state   <= IDLE;
          end
        end

        WR_DONE: begin
          if (!lv2_wr) begin
            lv2_wr_done <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lv2_bus_responder.sv
// Directed self-checking bench for lv2_bus_responder (MIN_LAT=2); released bus lines read as 0 via tri0.
module tb_lv2_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        lv2_rd;
  logic        lv2_wr;
  logic [31:0] addr;
  logic        tb_drv;
  logic [31:0] tb_wdata;
  logic        lv2_wr_done;
  logic        busy;
  tri0  [31:0] data_bus;
  tri0         data_in;
`ifdef LV2_RESP_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;

  lv2_bus_responder_if #(.ADDR_WID(32), .DATA_WID(32)) mem_if ();

  assign data_bus = tb_drv ? tb_wdata : 32'bz;

  lv2_bus_responder #(.DATA_WID(32), .ADDR_WID(32), .MIN_LAT(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lv2_rd              (lv2_rd),
    .lv2_wr              (lv2_wr),
    .addr_bus_lv1_lv2    (addr),
    .data_bus_lv1_lv2    (data_bus),
    .data_in_bus_lv1_lv2 (data_in),
    .lv2_wr_done         (lv2_wr_done),
    .mem                 (mem_if.master),
`ifdef LV2_RESP_STATS_EN
    .rd_count            (rd_count),
    .wr_count            (wr_count),
`endif
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; lv2_rd = 1'b0; lv2_wr = 1'b0; addr = '0;
    tb_drv = 1'b0; tb_wdata = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    tick(); tick();
    check("rst_mem_req", mem_if.mem_req, 0);
    check("rst_mem_we", mem_if.mem_we, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_mem_wdata", mem_if.mem_wdata, 0);
    check("rst_wr_done", lv2_wr_done, 0);
    check("rst_busy", busy, 0);
    check("rst_data_in", data_in, 0);
    check("rst_data_bus", data_bus, 0);
    rst = 1'b0;
    tick();

    // Stray ack while idle has no effect.
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    check("idle_ack_busy", busy, 0);
    check("idle_ack_req", mem_if.mem_req, 0);

    // Reset in the middle of a read access, then a fresh read.
    lv2_rd = 1'b1; addr = 32'h0000_0500;
    tick();
    check("rst_mid_req_before", mem_if.mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", mem_if.mem_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data_in", data_in, 0);
    check("rst_mid_addr", mem_if.mem_addr, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_capture_req", mem_if.mem_req, 1);
    check("post_rst_capture_addr", mem_if.mem_addr, 32'h0000_0500);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h0000_600D;
    tick();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    tick();
    exp_rd++;
    check("post_rst_data_in", data_in, 1);
    check("post_rst_data_bus", data_bus, 32'h0000_600D);
    lv2_rd = 1'b0;
    tick();
    check("post_rst_release", data_in, 0);

    // Basic read: ack one cycle after capture, data valid two cycles after capture.
    lv2_rd = 1'b1; addr = 32'h0000_0040;
    tick();
    check("rd_req", mem_if.mem_req, 1);
    check("rd_we", mem_if.mem_we, 0);
    check("rd_addr", mem_if.mem_addr, 32'h0000_0040);
    check("rd_busy", busy, 1);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hDEAD_BEEF;
    addr = 32'hFFFF_FFFF;
    tick();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    check("rd_req_dropped", mem_if.mem_req, 0);
    check("rd_not_early", data_in, 0);
    check("rd_addr_held", mem_if.mem_addr, 32'h0000_0040);
    tick();
    exp_rd++;
    check("rd_data_in", data_in, 1);
    check("rd_data_bus", data_bus, 32'hDEAD_BEEF);
    tick();
    check("rd_hold", data_bus, 32'hDEAD_BEEF);
    lv2_rd = 1'b0;
    tick();
    check("rd_release_in", data_in, 0);
    check("rd_release_bus", data_bus, 0);
    check("rd_idle_busy", busy, 0);

    // Slow L2: ack arrives in the seventh cycle of the request.
    lv2_rd = 1'b1; addr = 32'h0000_0300;
    tick();
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("slow_req_c%0d", i), {mem_if.mem_req, data_in}, 2'b10);
      tick();
    end
    check("slow_req_c7", mem_if.mem_req, 1);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFE_0001;
    tick();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    exp_rd++;
    check("slow_req_done", mem_if.mem_req, 0);
    check("slow_data_in", data_in, 1);
    check("slow_data_bus", data_bus, 32'hCAFE_0001);
    lv2_rd = 1'b0;
    tick();
    check("slow_release", data_in, 0);

    // Simultaneous read and write: read first, write after an idle cycle.
    lv2_rd = 1'b1; lv2_wr = 1'b1; addr = 32'h0000_0100;
    tick();
    check("sim_rd_addr", mem_if.mem_addr, 32'h0000_0100);
    check("sim_rd_we", mem_if.mem_we, 0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hA5A5_0100;
    tick();
    mem_if.mem_ack = 1'b0;
    tick();
    exp_rd++;
    check("sim_rd_bus", data_bus, 32'hA5A5_0100);
    lv2_rd = 1'b0; addr = 32'h0000_0200;
    tick();
    check("sim_idle_busy", busy, 0);
    check("sim_idle_release", data_in, 0);
    tb_drv = 1'b1; tb_wdata = 32'h0BAD_F00D;
    tick();
    check("sim_wr_we", mem_if.mem_we, 1);
    check("sim_wr_addr", mem_if.mem_addr, 32'h0000_0200);
    check("sim_wr_wdata", mem_if.mem_wdata, 32'h0BAD_F00D);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    tick();
    exp_wr++;
    check("sim_wr_done", lv2_wr_done, 1);
    lv2_wr = 1'b0; tb_drv = 1'b0;
    tick();
    check("sim_wr_done_clr", lv2_wr_done, 0);

    // Basic write with bus changes after capture.
    lv2_wr = 1'b1; addr = 32'h0000_0080; tb_drv = 1'b1; tb_wdata = 32'h1234_5678;
    tick();
    check("wr_req", mem_if.mem_req, 1);
    check("wr_we", mem_if.mem_we, 1);
    check("wr_addr", mem_if.mem_addr, 32'h0000_0080);
    check("wr_wdata", mem_if.mem_wdata, 32'h1234_5678);
    tb_wdata = 32'hFFFF_FFFF; addr = '0;
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    check("wr_wdata_held", mem_if.mem_wdata, 32'h1234_5678);
    check("wr_not_early", lv2_wr_done, 0);
    tick();
    exp_wr++;
    check("wr_done", lv2_wr_done, 1);
    tick();
    check("wr_done_held", lv2_wr_done, 1);
    lv2_wr = 1'b0; tb_drv = 1'b0;
    tick();
    check("wr_done_clr", lv2_wr_done, 0);
    check("wr_idle_busy", busy, 0);

    // Withdrawn read: L2 access still completes, bus never driven.
    lv2_rd = 1'b1; addr = 32'h0000_0400;
    tick();
    lv2_rd = 1'b0;
    tick(); tick();
    check("wd_req_held", mem_if.mem_req, 1);
    check("wd_busy", busy, 1);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h1111_2222;
    tick();
    mem_if.mem_ack = 1'b0;
    check("wd_idle", busy, 0);
    check("wd_no_drive", data_in, 0);
    tick();
    check("wd_bus_released", data_bus, 0);

`ifdef LV2_RESP_STATS_EN
    check("stat_rd_count", rd_count, exp_rd);
    check("stat_wr_count", wr_count, exp_wr);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
